spi_flash_loader: RTL and testbench
===================================

# spi_flash_loader

Autonomous boot-time bitstream source for the eFPGA configuration port. On a start pulse it reads a length-prefixed image from an external SPI NOR flash using the standard READ (0x03) command, packs the bytes into 32-bit words and emits them on the same word-write interface that the USB configuration path drives. It sits in the controller next to the USB configuration block; the controller multiplexes the two word streams onto `efpga_write_data_o` / `efpga_write_strobe_o` and drives the flash pins (`sck_o`, `cs_o`, `pico_o`, `poci_i`) from this block.

## Interface
- `CLK_DIV`, 2: SCK half-period in `clk_i` cycles; legal range 1..255.
- `START_ADDR`, 24'h100000: flash byte address of the image length word.
- `MAX_WORDS`, 65536: largest accepted payload word count.

- `clk_i`  in  1  system clock; the block's only clock.
- `reset_i`  in  1  synchronous, active-high reset.
- `start_i`  in  1  single-cycle start request; honoured only in IDLE.
- `busy_o`  out  1  high from accepted start until return to IDLE.
- `done_o`  out  1  sticky: image loaded; cleared by next accepted start.
- `error_o`  out  1  sticky: length > MAX_WORDS; cleared by next accepted start.
- `sck_o`  out  1  SPI clock, mode 0 (idle low).
- `cs_o`  out  1  flash chip select, active low.
- `pico_o`  out  1  controller-to-flash data, MSB first.
- `poci_i`  in  1  flash-to-controller data.
- `write_data_o`  out  32  payload word; first received byte in [31:24].
- `word_write_strobe_o`  out  1  one-cycle pulse per valid `write_data_o`.

## Operation
- Image format at START_ADDR: 32-bit big-endian word count N, then N payload words, big-endian.
- States: IDLE, CS_SETUP, CMD, LEN, DATA, CS_HOLD.
- IDLE: `start_i`=1 -> clear `done_o`/`error_o`, set `busy_o`, drive `cs_o`=0, go CS_SETUP.
- CS_SETUP: CLK_DIV cycles with `sck_o`=0, `pico_o` = bit 31 of command word; then CMD.
- CMD: shift out 32 bits {8'h03, START_ADDR}, MSB first; then LEN.
- LEN: shift in 32 bits into length register; `pico_o` held 0. N==0 -> CS_HOLD with `done_o` path; N > MAX_WORDS -> CS_HOLD with `error_o` path, no strobes; else DATA.
- DATA: shift in 32 bits per word; after bit 0 of each word, load `write_data_o`, pulse strobe, decrement remaining count; after word N go CS_HOLD.
- CS_HOLD: `sck_o`=0 for CLK_DIV cycles, then `cs_o`=1, `busy_o`=0, set `done_o` or `error_o`, go IDLE.
- Flash reads continue across the whole image in one transaction (no re-addressing).
- Word counter width: clog2(MAX_WORDS+1); length compare uses full 32-bit N.

## Timing
- Reset values: `sck_o`=0, `cs_o`=1, `pico_o`=0, `busy_o`=0, `done_o`=0, `error_o`=0, `write_data_o`=0, `word_write_strobe_o`=0.
- Each bit: CLK_DIV cycles `sck_o` low, then CLK_DIV cycles high.
- `pico_o` changes only on the edge that drives `sck_o` low (and on CS_SETUP entry).
- `poci_i` captured on the clk edge that drives `sck_o` from 1 to 0 (end of high phase).
- With start accepted at edge E0 (CS_SETUP entered), strobe for payload word k (0-based) is high in the cycle after edge E0 + CLK_DIV + (96+32k)·2·CLK_DIV; `write_data_o` stable until next strobe.
- `cs_o` rises CLK_DIV cycles after the last SCK high phase ends; `done_o`/`error_o` set same edge.
- `start_i` while busy: ignored, no effect on state or flags.
- `reset_i` mid-transfer: all outputs return to reset values on the next edge, `cs_o`=1 immediately, no further strobes; reset wins over simultaneous `start_i`.

## Test plan
- Flash model, CLK_DIV=2, N=3, words 0xDEADBEEF, 0x01234567, 0xA5A55A5A -> pico sequence 0x03,0x10,0x00,0x00; exactly 3 strobes with those values in order at the cycles given above; `done_o`=1, `error_o`=0, `cs_o`=1 after.
- N=0 -> zero strobes, 64 SCK rising edges total, `done_o`=1.
- N=0x00010001 with MAX_WORDS=65536 -> zero strobes, `error_o`=1, `done_o`=0, `cs_o`=1.
- CLK_DIV=1, N=1, word 0x80000001 -> SCK period 2 cycles, single strobe 0x80000001.
- `start_i` pulsed repeatedly during DATA -> no restart, strobe count unchanged, flags correct at end.
- `reset_i` asserted after 1 of 4 words -> next edge `cs_o`=1, `sck_o`=0, `busy_o`=0, no more strobes; fresh `start_i` then loads all 4 words.

Source files
------------

// File: rtl/spi_flash_loader.sv
// spi_flash_loader: boot-time bitstream source for the eFPGA configuration port.
// Reads a length-prefixed image from SPI NOR flash with READ (0x03) in a single
// chip-select transaction and emits the payload as 32-bit word writes.
//
// state       | meaning
// ------------+----------------------------------------------------------
// ST_IDLE     | waiting for start_i; cs_o high, sck_o low
// ST_CS_SETUP | cs_o low, first command bit on pico_o, CLK_DIV cycles
// ST_CMD      | shifting out {8'h03, START_ADDR}, MSB first
// ST_LEN      | shifting in the 32-bit big-endian word count
// ST_DATA     | shifting in payload words, one strobe per word
// ST_CS_HOLD  | sck_o low for CLK_DIV cycles, then release cs_o and flag result
module spi_flash_loader #(
    parameter int unsigned CLK_DIV    = 2,
    parameter logic [23:0] START_ADDR = 24'h100000,
    parameter int unsigned MAX_WORDS  = 65536
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic        sck_o,
    output logic        cs_o,
    output logic        pico_o,
    input  logic        poci_i,
    output logic [31:0] write_data_o,
    output logic        word_write_strobe_o
);

    localparam int          CNT_W    = $clog2(MAX_WORDS + 1);
    localparam logic [7:0]  DIV_LOAD = 8'(CLK_DIV - 1);
    localparam logic [31:0] CMD_WORD = {8'h03, START_ADDR};
    localparam logic [31:0] MAX_N    = 32'(MAX_WORDS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_CMD,
        ST_LEN,
        ST_DATA,
        ST_CS_HOLD
    } state_t;

    state_t           state;
    logic [7:0]       div_cnt;     // half-period down-counter
    logic [4:0]       bit_cnt;     // bits left in the current 32-bit field
    logic [30:0]      shift_out;   // command bits still to be sent after pico_o
    logic [30:0]      shift_in;    // bits of the current field received so far
    logic [CNT_W-1:0] words_left;
    logic             fail_flag;   // result reported when CS_HOLD completes

    logic             div_tc;
    logic             last_bit;
    logic [31:0]      shift_next;

    assign div_tc     = (div_cnt == 8'd0);
    assign last_bit   = (bit_cnt == 5'd0);
    // Field value including the bit captured at the end of the current high phase.
    assign shift_next = {shift_in, poci_i};

    // Sequencer: SCK generation, command shift-out, length/payload shift-in, flags.
    always_ff @(posedge clk_i) begin
        word_write_strobe_o <= 1'b0;
        if (reset_i) begin
            state        <= ST_IDLE;
            div_cnt      <= 8'd0;
            bit_cnt      <= 5'd0;
            shift_out    <= '0;
            shift_in     <= '0;
            words_left   <= '0;
            fail_flag    <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            error_o      <= 1'b0;
            sck_o        <= 1'b0;
            cs_o         <= 1'b1;
            pico_o       <= 1'b0;
            write_data_o <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        done_o    <= 1'b0;
                        error_o   <= 1'b0;
                        busy_o    <= 1'b1;
                        cs_o      <= 1'b0;
                        sck_o     <= 1'b0;
                        pico_o    <= CMD_WORD[31];
                        shift_out <= CMD_WORD[30:0];
                        div_cnt   <= DIV_LOAD;
                        state     <= ST_CS_SETUP;
                    end
                end

                ST_CS_SETUP: begin
                    if (div_tc) begin
                        div_cnt <= DIV_LOAD;
                        bit_cnt <= 5'd31;
                        state   <= ST_CMD;
                    end else begin
                        div_cnt <= div_cnt - 8'd1;
                    end
                end

                ST_CMD, ST_LEN, ST_DATA: begin
                    if (!div_tc) begin
                        div_cnt <= div_cnt - 8'd1;
                    end else begin
                        div_cnt <= DIV_LOAD;
                        sck_o   <= ~sck_o;
                        // End of a high phase closes one bit: sample poci, advance pico.
                        if (sck_o) begin
                            bit_cnt   <= bit_cnt - 5'd1;
                            shift_in  <= shift_next[30:0];
                            shift_out <= {shift_out[29:0], 1'b0};
                            pico_o    <= (state == ST_CMD && !last_bit) ? shift_out[30] : 1'b0;
                            if (last_bit) begin
                                case (state)
                                    ST_CMD: begin
                                        state <= ST_LEN;
                                    end
                                    ST_LEN: begin
                                        if (shift_next == 32'd0) begin
                                            fail_flag <= 1'b0;
                                            state     <= ST_CS_HOLD;
                                        end else if (shift_next > MAX_N) begin
                                            fail_flag <= 1'b1;
                                            state     <= ST_CS_HOLD;
                                        end else begin
                                            words_left <= shift_next[CNT_W-1:0];
                                            state      <= ST_DATA;
                                        end
                                    end
                                    default: begin
                                        write_data_o        <= shift_next;
                                        word_write_strobe_o <= 1'b1;
                                        words_left          <= words_left - CNT_W'(1);
                                        if (words_left == CNT_W'(1)) begin
                                            fail_flag <= 1'b0;
                                            state     <= ST_CS_HOLD;
                                        end
                                    end
                                endcase
                            end
                        end
                    end
                end

                ST_CS_HOLD: begin
                    if (div_tc) begin
                        cs_o    <= 1'b1;
                        busy_o  <= 1'b0;
                        done_o  <= ~fail_flag;
                        error_o <= fail_flag;
                        state   <= ST_IDLE;
                    end else begin
                        div_cnt <= div_cnt - 8'd1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_loader.sv
// Bench for spi_flash_loader: two instances (CLK_DIV=2 and CLK_DIV=1), each with a
// behavioural SPI NOR model; expected words and strobe cycles go into scoreboards.
module tb_spi_flash_loader;

    localparam logic [23:0] BASE = 24'h100000;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;
    logic start0 = 1'b0, start1 = 1'b0;
    logic busy0, done0, err0, sck0, cs0, pico0, strb0;
    logic busy1, done1, err1, sck1, cs1, pico1, strb1;
    logic [31:0] wd0, wd1;
    logic poci0 = 1'b0, poci1 = 1'b0;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   e0      = 0;
    int   str0    = 0;
    int   str1    = 0;
    exp_t q0[$];
    exp_t q1[$];

    spi_flash_loader #(.CLK_DIV(2), .START_ADDR(BASE), .MAX_WORDS(65536)) u_dut0 (
        .clk_i(clk), .reset_i(reset), .start_i(start0), .busy_o(busy0), .done_o(done0),
        .error_o(err0), .sck_o(sck0), .cs_o(cs0), .pico_o(pico0), .poci_i(poci0),
        .write_data_o(wd0), .word_write_strobe_o(strb0)
    );

    spi_flash_loader #(.CLK_DIV(1), .START_ADDR(BASE), .MAX_WORDS(65536)) u_dut1 (
        .clk_i(clk), .reset_i(reset), .start_i(start1), .busy_o(busy1), .done_o(done1),
        .error_o(err1), .sck_o(sck1), .cs_o(cs1), .pico_o(pico1), .poci_i(poci1),
        .write_data_o(wd1), .word_write_strobe_o(strb1)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Flash model 0: capture command/address on SCK rise, drive data on SCK fall.
    logic [7:0]  fmem0 [64];
    int          bitn0 = 0, rise0 = 0;
    logic [31:0] cap0 = 32'd0;
    always @(posedge sck0 or posedge cs0) begin
        if (cs0) bitn0 = 0;
        else begin
            if (bitn0 < 32) cap0 = {cap0[30:0], pico0};
            bitn0 = bitn0 + 1;
            rise0 = rise0 + 1;
        end
    end
    always @(negedge sck0) begin : fdrv0
        int j;
        logic [23:0] a;
        if (!cs0 && bitn0 >= 32) begin
            j     = bitn0 - 32;
            a     = cap0[23:0] - BASE + 24'(j / 8);
            poci0 = fmem0[a[5:0]][7 - (j % 8)];
        end
    end

    // Flash model 1, same behaviour for the CLK_DIV=1 instance.
    logic [7:0]  fmem1 [64];
    int          bitn1 = 0, rise1 = 0;
    logic [31:0] cap1 = 32'd0;
    always @(posedge sck1 or posedge cs1) begin
        if (cs1) bitn1 = 0;
        else begin
            if (bitn1 < 32) cap1 = {cap1[30:0], pico1};
            bitn1 = bitn1 + 1;
            rise1 = rise1 + 1;
        end
    end
    always @(negedge sck1) begin : fdrv1
        int j;
        logic [23:0] a;
        if (!cs1 && bitn1 >= 32) begin
            j     = bitn1 - 32;
            a     = cap1[23:0] - BASE + 24'(j / 8);
            poci1 = fmem1[a[5:0]][7 - (j % 8)];
        end
    end

    // Monitors: every strobe must match the head of its scoreboard in value and cycle.
    always @(negedge clk) begin : mon0
        exp_t e;
        if (strb0 === 1'b1) begin
            str0 <= str0 + 1;
            if (q0.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL dut0 strobe: got strobe with data 0x%08h at cycle %0d, expected none", wd0, cyc);
            end else begin
                e = q0.pop_front();
                chk("dut0 word data", wd0, e.data);
                chk("dut0 strobe cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        if (strb1 === 1'b1) begin
            str1 <= str1 + 1;
            if (q1.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL dut1 strobe: got strobe with data 0x%08h at cycle %0d, expected none", wd1, cyc);
            end else begin
                e = q1.pop_front();
                chk("dut1 word data", wd1, e.data);
                chk("dut1 strobe cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic prog(input int inst, input logic [31:0] n, input logic [31:0] w [4]);
        logic [31:0] v;
        for (int i = 0; i < 5; i++) begin
            v = (i == 0) ? n : w[i-1];
            for (int b = 0; b < 4; b++) begin
                if (inst == 0) fmem0[i*4+b] = v[31-8*b -: 8];
                else           fmem1[i*4+b] = v[31-8*b -: 8];
            end
        end
    endtask

    // Pulse start, note the acceptance edge and queue the expected strobes.
    task automatic launch(input int inst, input int nexp, input logic [31:0] w [4]);
        int   d;
        exp_t e;
        d = (inst == 0) ? 2 : 1;
        @(negedge clk);
        if (inst == 0) start0 = 1'b1;
        else           start1 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        e0 = cyc;
        for (int k = 0; k < nexp; k++) begin
            e.data = w[k];
            e.cyc  = e0 + d + (96 + 32 * k) * 2 * d;
            if (inst == 0) q0.push_back(e);
            else           q1.push_back(e);
        end
    endtask

    // Wait for busy to drop; nbits is the number of SCK bits in the transaction.
    task automatic wait_end(input int inst, input int nbits, input string tag);
        int   d, lim;
        logic b;
        d   = (inst == 0) ? 2 : 1;
        lim = 0;
        do begin
            @(negedge clk);
            lim++;
            b = (inst == 0) ? busy0 : busy1;
        end while (b !== 1'b0 && lim < 20000);
        if (b !== 1'b0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s timeout: busy still %b after %0d cycles, expected 0", tag, b, lim);
        end else begin
            chk({tag, " cs release cycle"}, 32'(cyc), 32'(e0 + d + nbits * 2 * d + d));
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] wv [4];
        int r0, s0, lim;

        repeat (3) @(negedge clk);
        chk("reset cs_o", {31'd0, cs0}, 32'd1);
        chk("reset sck_o", {31'd0, sck0}, 32'd0);
        chk("reset pico_o", {31'd0, pico0}, 32'd0);
        chk("reset busy_o", {31'd0, busy0}, 32'd0);
        chk("reset done_o", {31'd0, done0}, 32'd0);
        chk("reset error_o", {31'd0, err0}, 32'd0);
        chk("reset write_data_o", wd0, 32'd0);
        chk("reset strobe", {31'd0, strb0}, 32'd0);
        chk("reset dut1 cs_o", {31'd0, cs1}, 32'd1);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Three-word image at CLK_DIV=2.
        wv = '{32'hDEADBEEF, 32'h01234567, 32'hA5A55A5A, 32'h0};
        prog(0, 32'd3, wv);
        r0 = rise0;
        launch(0, 3, wv);
        chk("n3 busy after start", {31'd0, busy0}, 32'd1);
        chk("n3 cs low after start", {31'd0, cs0}, 32'd0);
        wait_end(0, 64 + 3 * 32, "n3");
        chk("n3 command/address", cap0, 32'h03100000);
        chk("n3 done", {31'd0, done0}, 32'd1);
        chk("n3 error", {31'd0, err0}, 32'd0);
        chk("n3 cs high", {31'd0, cs0}, 32'd1);
        chk("n3 sck rises", 32'(rise0 - r0), 32'd160);
        chk("n3 words pending", 32'(q0.size()), 32'd0);
        chk("n3 write_data held", wd0, 32'hA5A55A5A);

        // Empty image.
        prog(0, 32'd0, wv);
        r0 = rise0;
        s0 = str0;
        launch(0, 0, wv);
        chk("n0 done cleared by start", {31'd0, done0}, 32'd0);
        wait_end(0, 64, "n0");
        chk("n0 sck rises", 32'(rise0 - r0), 32'd64);
        chk("n0 strobes", 32'(str0 - s0), 32'd0);
        chk("n0 done", {31'd0, done0}, 32'd1);
        chk("n0 error", {31'd0, err0}, 32'd0);

        // Oversized length is rejected after the length field.
        prog(0, 32'h00010001, wv);
        r0 = rise0;
        s0 = str0;
        launch(0, 0, wv);
        wait_end(0, 64, "big");
        chk("big strobes", 32'(str0 - s0), 32'd0);
        chk("big error", {31'd0, err0}, 32'd1);
        chk("big done", {31'd0, done0}, 32'd0);
        chk("big cs high", {31'd0, cs0}, 32'd1);
        chk("big sck rises", 32'(rise0 - r0), 32'd64);

        // Single word at CLK_DIV=1.
        wv = '{32'h80000001, 32'h0, 32'h0, 32'h0};
        prog(1, 32'd1, wv);
        r0 = rise1;
        launch(1, 1, wv);
        wait_end(1, 64 + 32, "div1");
        chk("div1 command/address", cap1, 32'h03100000);
        chk("div1 strobes", 32'(str1), 32'd1);
        chk("div1 sck rises", 32'(rise1 - r0), 32'd96);
        chk("div1 done", {31'd0, done1}, 32'd1);
        chk("div1 words pending", 32'(q1.size()), 32'd0);

        // start_i pulsed while the payload is streaming must be ignored.
        wv = '{32'hFFFFFFFF, 32'h00000000, 32'h7E7E8181, 32'h0};
        prog(0, 32'd3, wv);
        s0 = str0;
        launch(0, 3, wv);
        chk("busy start error cleared", {31'd0, err0}, 32'd0);
        repeat (300) @(negedge clk);
        for (int p = 0; p < 3; p++) begin
            start0 = 1'b1;
            @(negedge clk);
            start0 = 1'b0;
            repeat (40) @(negedge clk);
        end
        chk("busy start done low mid-run", {31'd0, done0}, 32'd0);
        wait_end(0, 64 + 3 * 32, "busy start");
        chk("busy start strobes", 32'(str0 - s0), 32'd3);
        chk("busy start done", {31'd0, done0}, 32'd1);
        chk("busy start error", {31'd0, err0}, 32'd0);

        // Reset after the first of four words, with a simultaneous start.
        wv = '{32'hCAFEF00D, 32'h0BADC0DE, 32'h13579BDF, 32'h2468ACE0};
        prog(0, 32'd4, wv);
        s0 = str0;
        launch(0, 4, wv);
        lim = 0;
        while (str0 == s0 && lim < 2000) begin
            @(negedge clk);
            lim++;
        end
        chk("reset test first word seen", 32'(str0 - s0), 32'd1);
        reset  = 1'b1;
        start0 = 1'b1;
        @(negedge clk);
        chk("midreset cs_o", {31'd0, cs0}, 32'd1);
        chk("midreset sck_o", {31'd0, sck0}, 32'd0);
        chk("midreset busy_o", {31'd0, busy0}, 32'd0);
        chk("midreset write_data_o", wd0, 32'd0);
        chk("midreset pico_o", {31'd0, pico0}, 32'd0);
        reset  = 1'b0;
        start0 = 1'b0;
        q0.delete();
        @(negedge clk);
        chk("midreset start ignored", {31'd0, busy0}, 32'd0);
        repeat (600) @(negedge clk);
        chk("midreset no more strobes", 32'(str0 - s0), 32'd1);
        s0 = str0;
        launch(0, 4, wv);
        wait_end(0, 64 + 4 * 32, "reload");
        chk("reload strobes", 32'(str0 - s0), 32'd4);
        chk("reload done", {31'd0, done0}, 32'd1);
        chk("reload words pending", 32'(q0.size()), 32'd0);

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
